// File: rtl/window_fetch_pkg.sv
// Shared defaults, tap geometry and FSM state encoding for the window fetch engine.
package window_fetch_pkg;

    localparam int DEF_FRAME_BASE  = 16;
    localparam int DEF_WINDOW_BASE = 16400;
    localparam int DEF_FRAME_COLS  = 64;
    localparam int WIN_DIM         = 4;
    localparam int NUM_TAPS        = WIN_DIM * WIN_DIM;
    localparam int TAP_W           = $clog2(NUM_TAPS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/window_addr_calc.sv
// Combinational byte-address generator for one window or frame tap.
module window_addr_calc
    import window_fetch_pkg::*;
#(
    parameter int FRAME_BASE  = DEF_FRAME_BASE,
    parameter int WINDOW_BASE = DEF_WINDOW_BASE,
    parameter int FRAME_COLS  = DEF_FRAME_COLS
) (
    input  logic [TAP_W-1:0] tap_idx,
    input  logic             is_window,
    input  logic [31:0]      offset,
    output logic [31:0]      addr
);

    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] word_off;

    // The 4x4 geometry lets row/column fall out of the tap index bits directly.
    always_comb begin
        row = {30'd0, tap_idx[3:2]};
        col = {30'd0, tap_idx[1:0]};
        if (is_window) begin
            word_off = {28'd0, tap_idx};
            addr     = 32'(WINDOW_BASE) + (word_off << 2);
        end else begin
            word_off = row * 32'(FRAME_COLS) + col + offset;
            addr     = 32'(FRAME_BASE) + (word_off << 2);
        end
    end

endmodule

// File: rtl/window_fetcher.sv
// Issues window/frame tap reads over a valid/ready channel and captures the
// in-order responses into two packed tap buffers.
module window_fetcher
    import window_fetch_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int FRAME_BASE      = DEF_FRAME_BASE,
    parameter int WINDOW_BASE     = DEF_WINDOW_BASE,
    parameter int FRAME_COLS      = DEF_FRAME_COLS,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       reload_window,
    input  logic [31:0]                current_address,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic [NUM_TAPS*DATA_W-1:0] frame_taps,
    output logic [NUM_TAPS*DATA_W-1:0] window_taps
);

    localparam int               OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    fetch_state_t     state, state_next;
    // Indices 0..15 address window taps, 16..31 frame taps; a cached window
    // simply starts both counters at 16.
    logic [4:0]       req_idx;
    logic [4:0]       rsp_idx;
    logic [OUT_W-1:0] outstanding;
    logic [31:0]      offset;
    logic             win_valid;
    logic [31:0]      calc_addr;
    logic             start_fire, req_fire, rsp_fire, last_req;
    logic [4:0]       first_idx;

    logic [DATA_W-1:0] frame_buf [NUM_TAPS];
    logic [DATA_W-1:0] win_buf   [NUM_TAPS];

    assign start_fire    = (state == IDLE) && start;
    assign mem_req_valid = (state == ISSUE) && (outstanding != OUT_MAX);
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign last_req      = (req_idx == 5'd31);
    assign rsp_fire      = mem_rsp_valid && ((state == ISSUE) || (state == DRAIN));
    assign mem_req_addr  = (state == ISSUE) ? calc_addr : '0;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign first_idx     = (win_valid && !reload_window) ? 5'd16 : 5'd0;

    window_addr_calc #(
        .FRAME_BASE (FRAME_BASE),
        .WINDOW_BASE(WINDOW_BASE),
        .FRAME_COLS (FRAME_COLS)
    ) u_addr_calc (
        .tap_idx  (req_idx[3:0]),
        .is_window(!req_idx[4]),
        .offset   (offset),
        .addr     (calc_addr)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (req_fire && last_req) state_next = DRAIN;
            DRAIN:   if (outstanding == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_idx     <= '0;
            rsp_idx     <= '0;
            outstanding <= '0;
            offset      <= '0;
            win_valid   <= 1'b0;
        end else begin
            if (start_fire) begin
                offset  <= current_address;
                req_idx <= first_idx;
                rsp_idx <= first_idx;
            end else begin
                if (req_fire && !last_req) req_idx <= req_idx + 5'd1;
                if (rsp_fire)              rsp_idx <= rsp_idx + 5'd1;
            end
            unique case ({req_fire, rsp_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (rsp_fire && (rsp_idx == 5'd15)) win_valid <= 1'b1;
        end
    end

    // NOTE: the tap buffers are reset explicitly because consumers rely on an
    // all-zero image after reset; plain storage arrays would normally skip it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                frame_buf[k] <= '0;
                win_buf[k]   <= '0;
            end
        end else if (rsp_fire) begin
            if (rsp_idx[4]) frame_buf[rsp_idx[3:0]] <= mem_rsp_data;
            else            win_buf[rsp_idx[3:0]]   <= mem_rsp_data;
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_pack
        assign frame_taps[k*DATA_W +: DATA_W]  = frame_buf[k];
        assign window_taps[k*DATA_W +: DATA_W] = win_buf[k];
    end

endmodule

// File: tb/tb_window_fetcher.sv
// Directed self-checking bench for window_fetcher with a latency-configurable
// in-order memory model.
module tb_window_fetcher;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          reload_window;
    logic [31:0]   current_address;
    logic          busy;
    logic          done;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [31:0]   mem_rsp_data;
    logic [511:0]  frame_taps;
    logic [511:0]  window_taps;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int exp_n    = 0;
    int bench_out = 0;
    int max_out   = 0;
    int cap_stall = 0;

    logic [31:0] req_log [$];
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    window_fetcher dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .reload_window  (reload_window),
        .current_address(current_address),
        .busy           (busy),
        .done           (done),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .frame_taps     (frame_taps),
        .window_taps    (window_taps)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] addr_of(input int k, input bit win, input logic [31:0] off);
        logic [31:0] r, c;
        r = 32'(k / 4);
        c = 32'(k % 4);
        if (win) return 32'd16400 + 32'd4 * (4 * r + c);
        return 32'd16 + 32'd4 * (r * 32'd64 + c + off);
    endfunction

    function automatic logic [511:0] exp_taps(input bit win, input logic [31:0] off);
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = mem_word(addr_of(k, win, off));
        return v;
    endfunction

    // Memory model and request/outstanding monitor.
    initial begin : mem_model
        logic        acc;
        logic [31:0] acc_addr;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            acc_addr = '0;
            if (!rst_n) begin
                bench_out = 0;
            end else begin
                if (bench_out > max_out) max_out = bench_out;
                if (busy && !mem_req_valid && bench_out == 4 && req_log.size() < exp_n)
                    cap_stall++;
                acc      = mem_req_valid && mem_req_ready;
                acc_addr = mem_req_addr;
                if (acc) req_log.push_back(acc_addr);
                bench_out = bench_out + int'(acc) - int'(mem_rsp_valid);
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mq_addr.delete();
                mq_due.delete();
                mem_rsp_valid = 1'b0;
            end else begin
                if (acc) begin
                    mq_addr.push_back(acc_addr);
                    mq_due.push_back(cyc + mem_lat - 1);
                end
                if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end else begin
                    mem_rsp_valid = 1'b0;
                end
            end
        end
    end

    int t0;

    task automatic start_fetch(input logic [31:0] off, input logic reload, input int n);
        req_log.delete();
        exp_n           = n;
        current_address = off;
        reload_window   = reload;
        start           = 1'b1;
        @(posedge clk);
        #1;
        t0              = cyc;
        start           = 1'b0;
        reload_window   = 1'b0;
        current_address = 32'hDEAD_BEEF;
    endtask

    task automatic wait_done(input string tag, output int edges);
        bit got = 0;
        edges = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (got) edges = cyc - t0;
        check({tag, "_done_seen"}, 512'(got), 512'(1));
        @(negedge clk);
        check({tag, "_idle_after"}, {busy, done}, 512'(0));
    endtask

    int          edges;
    logic [31:0] held;
    int          stable;

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        reload_window   = 1'b0;
        current_address = '0;
        mem_req_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, done, mem_req_valid}, 512'(0));
        check("rst_addr", mem_req_addr, 512'(0));
        check("rst_taps", frame_taps | window_taps, 512'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Cold start, offset 0: window then frame.
        start_fetch(32'd0, 1'b0, 32);
        @(negedge clk);
        check("cold_busy_valid", {busy, mem_req_valid}, 512'(2'b11));
        wait_done("cold", edges);
        check("cold_done_cycle", 512'(edges), 512'(34));
        check("cold_nreq", 512'(req_log.size()), 512'(32));
        check("cold_req0", req_log[0], 512'(16400));
        check("cold_req15", req_log[15], 512'(16460));
        check("cold_req16", req_log[16], 512'(16));
        check("cold_req19", req_log[19], 512'(28));
        check("cold_req20", req_log[20], 512'(272));
        check("cold_req31", req_log[31], 512'(796));
        check("cold_win0", window_taps[31:0], 512'(mem_word(32'd16400)));
        check("cold_win", window_taps, exp_taps(1, 32'd0));
        check("cold_frame", frame_taps, exp_taps(0, 32'd0));

        // Window cached, offset 5.
        start_fetch(32'd5, 1'b0, 16);
        wait_done("cached", edges);
        check("cached_done_cycle", 512'(edges), 512'(18));
        check("cached_nreq", 512'(req_log.size()), 512'(16));
        check("cached_req0", req_log[0], 512'(36));
        check("cached_req15", req_log[15], 512'(816));
        check("cached_win", window_taps, exp_taps(1, 32'd0));
        check("cached_frame", frame_taps, exp_taps(0, 32'd5));

        // Back-pressure: ready low for three cycles after five accepts.
        start_fetch(32'd2, 1'b0, 16);
        for (int i = 0; i < 200 && req_log.size() < 5; i++) begin
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b0;
        held   = mem_req_addr;
        stable = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_req_valid && mem_req_addr == held) stable++;
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        check("stall_stable", 512'(stable), 512'(3));
        check("stall_held_addr", held, 512'(284));
        wait_done("stall", edges);
        check("stall_nreq", 512'(req_log.size()), 512'(16));
        check("stall_req5", req_log[5], 512'(284));
        check("stall_frame", frame_taps, exp_taps(0, 32'd2));

        // Long latency with forced window reload: outstanding cap.
        mem_lat = 10;
        max_out = 0;
        cap_stall = 0;
        start_fetch(32'd0, 1'b1, 32);
        wait_done("lat10", edges);
        check("lat10_max_out", 512'(max_out), 512'(4));
        check("lat10_cap_stall", 512'(cap_stall > 0), 512'(1));
        check("lat10_nreq", 512'(req_log.size()), 512'(32));
        check("lat10_win", window_taps, exp_taps(1, 32'd0));
        check("lat10_frame", frame_taps, exp_taps(0, 32'd0));
        mem_lat = 1;

        // Offset wrap-around.
        start_fetch(32'hFFFF_FFFF, 1'b0, 16);
        wait_done("wrap", edges);
        check("wrap_req0", req_log[0], 512'(12));
        check("wrap_frame", frame_taps, exp_taps(0, 32'hFFFF_FFFF));

        // Reset at request 20 of a reload fetch.
        start_fetch(32'd1, 1'b1, 32);
        for (int i = 0; i < 200 && req_log.size() < 20; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mrst_ctrl", {busy, done, mem_req_valid}, 512'(0));
        check("mrst_addr", mem_req_addr, 512'(0));
        check("mrst_taps", frame_taps | window_taps, 512'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_fetch(32'd3, 1'b0, 32);
        wait_done("post_rst", edges);
        check("post_rst_done_cycle", 512'(edges), 512'(34));
        check("post_rst_nreq", 512'(req_log.size()), 512'(32));
        check("post_rst_req0", req_log[0], 512'(16400));
        check("post_rst_win", window_taps, exp_taps(1, 32'd0));
        check("post_rst_frame", frame_taps, exp_taps(0, 32'd3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
